// File: rtl/tx_fifo_wr_arbiter_pkg.sv
// Shared definitions for the TX FIFO control blocks: arbiter state encoding
// and the default burst length.
package tx_fifo_wr_arbiter_pkg;

   // One-hot grant encoding, so the state value doubles as the grant vector.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } arb_state_e;

   localparam int DEFAULT_BURST_LEN = 16;

endpackage

// File: rtl/tx_fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter into the TX FIFO. Bursts of up to
// BURST_LEN words per grant, stalled on almost-full, one-cycle write latency.
module tx_fifo_wr_arbiter
   import tx_fifo_wr_arbiter_pkg::*;
#(
   parameter int DAT_W     = 8,
   parameter int BURST_LEN = DEFAULT_BURST_LEN,
   parameter int CNT_W     = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_req0_valid,
   input  logic [DAT_W-1:0] i_req0_data,
   output logic             o_req0_ready,
   input  logic             i_req1_valid,
   input  logic [DAT_W-1:0] i_req1_data,
   output logic             o_req1_ready,
   input  logic             i_fifo_full,
   input  logic             i_fifo_afull,
   output logic             o_fifo_wr_en,
   output logic [DAT_W-1:0] o_fifo_wr_data,
   output logic [1:0]       o_grant,
   output logic [CNT_W-1:0] o_wr_total
);

   localparam int BC_W = $clog2(BURST_LEN + 1);

   arb_state_e       state;
   logic             last_gnt;
   logic [BC_W-1:0]  burst_cnt;
   logic             wr_en_q;
   logic [DAT_W-1:0] wr_data_q;
   logic [CNT_W-1:0] wr_total_q;

   logic             stall;
   logic             acc0;
   logic             acc1;
   logic             acc;
   logic [DAT_W-1:0] acc_data;
   logic             gnt_valid;
   logic             burst_last;

   // Afull is the stop condition: the flags are registered one cycle late,
   // so stopping on afull keeps the trailing registered write off a full FIFO.
   assign stall = i_fifo_afull | i_fifo_full;

   always_comb begin
      o_req0_ready = (state == ST_GNT0) & i_req0_valid & ~stall;
      o_req1_ready = (state == ST_GNT1) & i_req1_valid & ~stall;
      acc0         = i_req0_valid & o_req0_ready;
      acc1         = i_req1_valid & o_req1_ready;
      acc          = acc0 | acc1;
      acc_data     = acc1 ? i_req1_data : i_req0_data;
      gnt_valid    = (state == ST_GNT1) ? i_req1_valid : i_req0_valid;
      burst_last   = acc & (burst_cnt == BC_W'(BURST_LEN - 1));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         last_gnt   <= 1'b1;
         burst_cnt  <= '0;
         wr_en_q    <= 1'b0;
         wr_data_q  <= '0;
         wr_total_q <= '0;
      end else begin
         wr_en_q <= acc;
         if (acc)
            wr_data_q <= acc_data;
         if (wr_en_q)
            wr_total_q <= wr_total_q + CNT_W'(1);

         case (state)
            ST_IDLE: begin
               burst_cnt <= '0;
               // On contention, the requester not served last wins.
               if (i_req0_valid && i_req1_valid) begin
                  if (last_gnt) begin
                     state    <= ST_GNT0;
                     last_gnt <= 1'b0;
                  end else begin
                     state    <= ST_GNT1;
                     last_gnt <= 1'b1;
                  end
               end else if (i_req0_valid) begin
                  state    <= ST_GNT0;
                  last_gnt <= 1'b0;
               end else if (i_req1_valid) begin
                  state    <= ST_GNT1;
                  last_gnt <= 1'b1;
               end
            end
            ST_GNT0, ST_GNT1: begin
               // A stall freezes the burst entirely, even if valid drops.
               if (!stall) begin
                  if (acc)
                     burst_cnt <= burst_cnt + BC_W'(1);
                  if (!gnt_valid || burst_last)
                     state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_grant        = state;
   assign o_fifo_wr_en   = wr_en_q;
   assign o_fifo_wr_data = wr_data_q;
   assign o_wr_total     = wr_total_q;

endmodule

// File: doc/tx_fifo_wr_arbiter.md
TX_FIFO_WR_ARBITER -- requirements
Module: tx_fifo_wr_arbiter

Interface
REQ-001 SHALL have parameters: DAT_W, default 8, word width; BURST_LEN, default 16, maximum words per grant; CNT_W, default 16, total-counter width.
REQ-002 SHALL have ports: i_clk  in  1  sole clock, all logic on rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_req0_valid  in  1  requester 0 (UART RX path) word valid.
REQ-005 i_req0_data  in  DAT_W  requester 0 word.
REQ-006 o_req0_ready  out  1  requester 0 word accepted this cycle when valid&ready.
REQ-007 i_req1_valid, i_req1_data, o_req1_ready  in/in/out  1/DAT_W/1  requester 1 (DDR readback path), same semantics.
REQ-008 i_fifo_full  in  1  registered full flag of the TX FIFO write side.
REQ-009 i_fifo_afull  in  1  registered almost-full flag of the TX FIFO write side.
REQ-010 o_fifo_wr_en  out  1  FIFO write strobe.
REQ-011 o_fifo_wr_data  out  DAT_W  FIFO write word.
REQ-012 o_grant  out  2  one-hot current grant, 2'b00 when idle.
REQ-013 o_wr_total  out  CNT_W  words written since reset, wraps modulo 2^CNT_W.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1.
REQ-015 IDLE: if exactly one valid is high, go to that requester's GNT state next cycle.
REQ-016 IDLE, both valid: grant the requester not granted last; after reset requester 0 wins.
REQ-017 In GNTn, o_reqn_ready = i_reqn_valid & ~i_fifo_afull & ~i_fifo_full; the other ready is 0; both readys are 0 in IDLE.
REQ-018 Accepted word (valid&ready): o_fifo_wr_en=1 and o_fifo_wr_data=word on the next cycle (1-cycle registered latency); o_fifo_wr_en=0 otherwise.
REQ-019 Burst counter: cleared on entering GNTn, incremented per accepted word.
REQ-020 Burst ends on acceptance of word number BURST_LEN or on i_reqn_valid low while granted; next state is IDLE in both cases.
REQ-021 i_fifo_afull or i_fifo_full high while granted: stall; hold state and burst counter, no acceptance, no burst end.
REQ-022 Afull is the stop condition because the FIFO flags lag one cycle; the block SHALL never issue o_fifo_wr_en in a cycle where i_fifo_full is high.
REQ-023 o_grant reflects the FSM state combinationally.
REQ-024 o_wr_total increments by 1 per o_fifo_wr_en cycle and wraps from 2^CNT_W-1 to 0.
REQ-025 Last-grant register updates on every IDLE->GNTn transition.

Reset
REQ-026 While i_rst is high: state=IDLE, last-grant=1 (so requester 0 wins first), burst counter=0, o_fifo_wr_en=0, o_fifo_wr_data=0, o_grant=0, readys=0, o_wr_total=0.
REQ-027 Reset asserted mid-burst: a pending registered write is discarded, with no o_fifo_wr_en after reset release until a new acceptance.
REQ-028 First grant is possible on the cycle after i_rst deasserts.

Structure
REQ-029 FSM state encoding and a default BURST_LEN constant SHALL live in a shared package used by the other FIFO-control blocks.
REQ-030 Single module with no sub-modules; the round-robin pick is inline logic.

Verification
REQ-031 req0 streams 20 words 0x00..0x13, req1 idle, afull=0: o_grant=01, 16 writes 0x00..0x0F, one IDLE cycle, regrant, writes 0x10..0x13; o_wr_total=20.
REQ-032 Both valid from reset, each with 16 words, afull=0: order is req0 burst, req1 burst, with exactly 16 writes each and o_grant 01 then 10.
REQ-033 req1 streaming, afull asserted after the 5th accepted word for 3 cycles: ready drops the same cycle, no writes in the stall, burst resumes and ends after 16 total words.
REQ-034 req0 valid drops after 3 words: burst ends, IDLE; pending req1 granted next even though req0 revalidates.
REQ-035 i_rst pulsed mid-burst with a word accepted the prior cycle: o_fifo_wr_en=0 during and after reset; o_wr_total=0 and o_grant=00.
REQ-036 CNT_W=4, 17 writes: o_wr_total reads 15 then 0 then 1.
